// File: rtl/dac_ramp_gen.sv
// rtl/dac_ramp_gen.sv - setpoint ramp generator feeding the LTC2624 SPI DAC driver
// Optional handshake timeout enabled by defining DAC_RAMP_TIMEOUT_EN.
module dac_ramp_gen #(
   parameter int                DATA_W    = 12,
   parameter int                TICK_DIV  = 1000,
   parameter logic [DATA_W-1:0] INIT_CODE = '0,
   parameter int                BUSY_TO   = 4095
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] i_target,
   input  logic [DATA_W-1:0] i_step,
   input  logic              i_target_wr,
   input  logic              i_dac_cs,
   output logic [DATA_W-1:0] dac_data,
   output logic              i_dac_start,
   output logic              o_busy,
   output logic              o_at_target,
   output logic              o_timeout
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_START     = 2'd1;
   localparam logic [1:0] S_WAIT_LOW  = 2'd2;
   localparam logic [1:0] S_WAIT_HIGH = 2'd3;

   logic [TW-1:0]     tick_cnt;
   logic              tick;
   logic [1:0]        state;
   logic [DATA_W-1:0] cur;
   logic [DATA_W-1:0] tgt;
   logic [DATA_W-1:0] step;
   logic              init_pend;
   logic              waiting;
   logic              to_hit;

   logic [DATA_W:0]   cur_x;
   logic [DATA_W:0]   tgt_x;
   logic [DATA_W:0]   step_x;
   logic [DATA_W:0]   diff;
   logic [DATA_W:0]   next_x;
   logic [DATA_W-1:0] next_code;
   logic              unused_next_msb;

   assign tick = (tick_cnt == TW'(TICK_DIV - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   // One extra bit keeps cur +/- step from wrapping; the clamp to tgt bounds the result.
   always_comb begin
      cur_x  = {1'b0, cur};
      tgt_x  = {1'b0, tgt};
      step_x = {1'b0, step};
      diff   = (tgt_x >= cur_x) ? (tgt_x - cur_x) : (cur_x - tgt_x);
      if ((step_x == '0) || (step_x >= diff)) begin
         next_x = tgt_x;
      end else if (tgt_x > cur_x) begin
         next_x = cur_x + step_x;
      end else begin
         next_x = cur_x - step_x;
      end
   end

   assign next_code       = next_x[DATA_W-1:0];
   assign unused_next_msb = next_x[DATA_W];

   assign waiting = (state == S_WAIT_LOW) || (state == S_WAIT_HIGH);

`ifdef DAC_RAMP_TIMEOUT_EN
   localparam int TOW = (BUSY_TO > 1) ? $clog2(BUSY_TO + 1) : 1;

   logic [TOW-1:0] to_cnt;
   logic           timeout_q;

   assign to_hit = waiting && (to_cnt == TOW'(BUSY_TO - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         to_cnt    <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (waiting) begin
            to_cnt <= to_cnt + 1'b1;
         end else begin
            to_cnt <= '0;
         end
         if (to_hit) begin
            timeout_q <= 1'b1;
         end else if (i_target_wr) begin
            timeout_q <= 1'b0;
         end
      end
   end

   assign o_timeout = timeout_q;
`else
   logic unused_busy_to;

   assign to_hit         = 1'b0;
   assign o_timeout      = 1'b0;
   assign unused_busy_to = (BUSY_TO != 0);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         dac_data  <= INIT_CODE;
         cur       <= INIT_CODE;
         tgt       <= INIT_CODE;
         step      <= '0;
         init_pend <= 1'b1;
      end else begin
         if (i_target_wr) begin
            tgt  <= i_target;
            step <= i_step;
         end
         case (state)
            S_IDLE: begin
               if (tick && (init_pend || (cur != tgt))) begin
                  dac_data <= init_pend ? INIT_CODE : next_code;
                  state    <= S_START;
               end
            end
            S_START: begin
               state <= S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
               if (to_hit) begin
                  state <= S_IDLE;
               end else if (!i_dac_cs) begin
                  state <= S_WAIT_HIGH;
               end
            end
            S_WAIT_HIGH: begin
               // cur only advances once the driver has actually released cs.
               if (to_hit) begin
                  state <= S_IDLE;
               end else if (i_dac_cs) begin
                  cur       <= dac_data;
                  init_pend <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign i_dac_start = (state == S_START);
   assign o_busy      = (state != S_IDLE);
   assign o_at_target = (state == S_IDLE) && (cur == tgt) && !init_pend;

endmodule

// File: tb/tb_dac_ramp_gen.sv
// tb/tb_dac_ramp_gen.sv - self-checking bench for dac_ramp_gen
// Timeout scenario is exercised only when DAC_RAMP_TIMEOUT_EN is defined.
module tb_dac_ramp_gen;

   localparam int TD   = 8;
   localparam int BTO  = 64;
   localparam int INIT = 0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] i_target = '0;
   logic [11:0] i_step = '0;
   logic        i_target_wr = 1'b0;
   logic        i_dac_cs = 1'b1;
   logic [11:0] dac_data;
   logic        i_dac_start;
   logic        o_busy;
   logic        o_at_target;
   logic        o_timeout;

   int n_vec = 0;
   int n_err = 0;
   bit mon_en = 1'b1;
   bit stuck = 1'b0;

   always #5 clk = ~clk;

   dac_ramp_gen #(
      .DATA_W(12), .TICK_DIV(TD), .INIT_CODE(12'h000), .BUSY_TO(BTO)
   ) dut (
      .clk(clk), .rst(rst), .i_target(i_target), .i_step(i_step),
      .i_target_wr(i_target_wr), .i_dac_cs(i_dac_cs), .dac_data(dac_data),
      .i_dac_start(i_dac_start), .o_busy(o_busy), .o_at_target(o_at_target),
      .o_timeout(o_timeout)
   );

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int ramp_next(input int c, input int t, input int s);
      int d;
      d = (t > c) ? t - c : c - t;
      if (s == 0 || s >= d) return t;
      return (t > c) ? c + s : c - s;
   endfunction

   // Driver model: cs low 2 cycles after start, released 34 cycles later.
   initial begin
      int drv_cnt;
      drv_cnt = -1;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            drv_cnt  = -1;
            i_dac_cs = 1'b1;
         end else if (drv_cnt >= 0) begin
            drv_cnt++;
            if (drv_cnt == 2 && !stuck) i_dac_cs = 1'b0;
            if (drv_cnt == 36) begin
               i_dac_cs = 1'b1;
               drv_cnt  = -1;
            end
         end else if (i_dac_start) begin
            drv_cnt = 0;
         end
      end
   end

   // Reference model: ticks every TD cycles, one transfer per idle tick, commit on cs release.
   initial begin
      int m_cur, m_tgt, m_step, m_code, m_dac, m_cyc;
      bit m_pend, m_busy, m_due, m_low, tick, due;
      m_cur = INIT; m_tgt = INIT; m_step = 0; m_code = INIT; m_dac = INIT; m_cyc = 0;
      m_pend = 1; m_busy = 0; m_due = 0; m_low = 0;
      forever begin
         @(negedge clk);
         if (!mon_en) continue;
         if (rst) begin
            check("rst_start", i_dac_start, 0);
            check("rst_busy", o_busy, 0);
            check("rst_at_target", o_at_target, 0);
            check("rst_timeout", o_timeout, 0);
            check("rst_dac_data", dac_data, INIT);
            m_cur = INIT; m_tgt = INIT; m_step = 0; m_dac = INIT; m_cyc = 0;
            m_pend = 1; m_busy = 0; m_due = 0; m_low = 0;
            continue;
         end
         if (m_due) begin
            m_busy = 1;
            m_dac  = m_code;
            m_low  = 0;
         end
         check("mdl_start", i_dac_start, m_due);
         check("mdl_dac_data", dac_data, m_dac);
         check("mdl_busy", o_busy, m_busy);
         check("mdl_at_target", o_at_target, (!m_busy && m_cur == m_tgt && !m_pend));
         check("mdl_timeout", o_timeout, 0);
         tick = ((m_cyc % TD) == TD - 1);
         due  = tick && !m_busy && (m_pend || m_cur != m_tgt);
         if (due) m_code = m_pend ? INIT : ramp_next(m_cur, m_tgt, m_step);
         if (m_busy && !m_due) begin
            if (!i_dac_cs) begin
               m_low = 1;
            end else if (m_low) begin
               m_cur  = m_dac;
               m_pend = 0;
               m_busy = 0;
            end
         end
         m_due = due;
         if (i_target_wr) begin
            m_tgt  = i_target;
            m_step = i_step;
         end
         m_cyc++;
      end
   end

   task automatic step_cycle();
      @(posedge clk);
      #2;
   endtask

   task automatic write_tgt(input int t, input int s);
      step_cycle();
      i_target    = 12'(t);
      i_step      = 12'(s);
      i_target_wr = 1'b1;
      step_cycle();
      i_target_wr = 1'b0;
   endtask

   task automatic wait_start(output int code, output int cyc);
      code = -1;
      cyc  = -1;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (i_dac_start) begin
            code = dac_data;
            cyc  = k;
            return;
         end
      end
   endtask

   task automatic wait_at_target(input string name);
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (o_at_target) break;
      end
      check(name, o_at_target, 1);
   endtask

   task automatic no_start_for(input string name, input int cycles);
      int cnt;
      cnt = 0;
      for (int k = 0; k < cycles; k++) begin
         @(negedge clk);
         if (i_dac_start) cnt++;
      end
      check(name, cnt, 0);
   endtask

   typedef struct {
      int tgt;
      int stp;
      int n;
      int codes[3];
   } vec_t;

   initial begin
      vec_t tbl[4];
      int code, cyc, got;

      tbl[0] = '{234, 100, 3, '{100, 200, 234}};
      tbl[1] = '{10, 0, 1, '{10, 0, 0}};
      tbl[2] = '{4095, 4000, 2, '{4010, 4095, 0}};
      tbl[3] = '{0, 0, 1, '{0, 0, 0}};

      repeat (3) @(posedge clk);
      #2 rst = 1'b0;

      wait_start(code, cyc);
      check("init_code", code, INIT);
      check("init_latency", cyc, TD);
      wait_at_target("init_at_target");
      no_start_for("init_no_more_starts", 40);

      for (int i = 0; i < 4; i++) begin
         write_tgt(tbl[i].tgt, tbl[i].stp);
         for (int j = 0; j < tbl[i].n; j++) begin
            wait_start(code, cyc);
            check($sformatf("vec%0d_code%0d", i, j), code, tbl[i].codes[j]);
         end
         wait_at_target($sformatf("vec%0d_at_target", i));
         no_start_for($sformatf("vec%0d_quiet", i), 20);
      end

      write_tgt(400, 200);
      wait_start(code, cyc);
      check("wh_first_code", code, 200);
      repeat (8) step_cycle();
      write_tgt(50, 50);
      wait_start(code, cyc);
      check("wh_next_code", code, 150);
      wait_start(code, cyc);
      check("wh_code_100", code, 100);
      wait_start(code, cyc);
      check("wh_code_50", code, 50);
      wait_at_target("wh_at_target");

      write_tgt(50, 7);
      no_start_for("same_tgt_no_xfer", 40);
      check("same_tgt_at_target", o_at_target, 1);

      write_tgt(1000, 0);
      wait_start(code, cyc);
      check("rwl_code", code, 1000);
      step_cycle();
      rst = 1'b1;
      @(negedge clk);
      check("rwl_start", i_dac_start, 0);
      check("rwl_busy", o_busy, 0);
      check("rwl_dac_data", dac_data, INIT);
      repeat (2) step_cycle();
      rst = 1'b0;
      wait_start(code, cyc);
      check("rwl_init_code", code, INIT);
      check("rwl_init_latency", cyc, TD);
      wait_at_target("rwl_at_target");

      for (int i = 0; i < 40; i++) begin
         int sel, s;
         repeat ($urandom_range(0, 120)) step_cycle();
         sel = $urandom_range(0, 3);
         case (sel)
            0: s = 0;
            1: s = $urandom_range(1, 64);
            2: s = $urandom_range(65, 1500);
            default: s = $urandom_range(1501, 4095);
         endcase
         write_tgt($urandom_range(0, 4095), s);
      end
      write_tgt($urandom_range(0, 4095), 0);
      wait_at_target("rand_final_at_target");

`ifdef DAC_RAMP_TIMEOUT_EN
      write_tgt(50, 0);
      wait_at_target("to_setup");
      mon_en = 1'b0;
      stuck  = 1'b1;
      write_tgt(300, 100);
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (o_timeout) break;
      end
      check("to_flag_set", o_timeout, 1);
      check("to_idle", o_busy, 0);
      check("to_not_at_target", o_at_target, 0);
      step_cycle();
      i_target    = 12'd300;
      i_step      = 12'd100;
      i_target_wr = 1'b1;
      stuck       = 1'b0;
      @(negedge clk);
      got = i_dac_start ? int'(dac_data) : -1;
      step_cycle();
      i_target_wr = 1'b0;
      @(negedge clk);
      check("to_flag_clear", o_timeout, 0);
      if (got < 0 && i_dac_start) got = dac_data;
      for (int k = 0; k < 100 && got < 0; k++) begin
         @(negedge clk);
         if (i_dac_start) got = dac_data;
      end
      check("to_cur_kept", got, 150);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end

endmodule
